// File: rtl/sseg_scan_reader_pkg.sv
// Shared definitions for the seven-segment scan reader: emitted digit patterns,
// FSM encodings, decoder result type and the anode one-hot-low check.
package sseg_scan_reader_pkg;

    localparam logic [6:0] SSEG_BLANK = 7'b1111111;
    localparam logic [6:0] SSEG_0     = 7'b0000001;
    localparam logic [6:0] SSEG_1     = 7'b1111001;
    localparam logic [6:0] SSEG_2     = 7'b0010010;
    localparam logic [6:0] SSEG_3     = 7'b0000110;
    localparam logic [6:0] SSEG_4     = 7'b1001100;
    localparam logic [6:0] SSEG_5     = 7'b0100100;
    localparam logic [6:0] SSEG_6     = 7'b0100000;
    localparam logic [6:0] SSEG_7     = 7'b0001111;
    localparam logic [6:0] SSEG_8     = 7'b0000000;
    localparam logic [6:0] SSEG_9     = 7'b0001100;
    localparam logic [6:0] SSEG_A     = 7'b0001000;
    localparam logic [6:0] SSEG_B     = 7'b1100000;
    localparam logic [6:0] SSEG_C     = 7'b0110001;
    localparam logic [6:0] SSEG_D     = 7'b1000010;
    localparam logic [6:0] SSEG_E     = 7'b0110000;
    localparam logic [6:0] SSEG_F     = 7'b0111000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    typedef struct packed {
        logic       blank;
        logic       invalid;
        logic [3:0] nibble;
    } dec_t;

    // Caller pads unused upper anode bits with ones; exactly one low bit is valid.
    function automatic logic is_onehot_low(input logic [31:0] an_pad);
        logic [31:0] hot;
        hot = ~an_pad;
        return (hot != 32'd0) && ((hot & (hot - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/sseg_scan_reader_if.sv
// Display bus seen by the scan reader: display-path drive plus captured-frame results.
interface sseg_scan_reader_if #(
    parameter int unsigned NDIG = 4
);
    logic [NDIG-1:0]   an;
    logic [6:0]        sseg;
    logic              signo;
    logic [4*NDIG-1:0] value;
    logic [NDIG-1:0]   blank_mask;
    logic              neg;
    logic              frame_valid;
    logic              err;
    logic              timeout;

    modport master (
        output an, sseg, signo,
        input  value, blank_mask, neg, frame_valid, err, timeout
    );

    modport slave (
        input  an, sseg, signo,
        output value, blank_mask, neg, frame_valid, err, timeout
    );
endinterface

// File: rtl/sseg_scan_reader_decode.sv
// Combinational 7-segment code to nibble decoder; also used by the display-path
// assertion checker, so it carries no state.
module sseg_scan_reader_decode
    import sseg_scan_reader_pkg::*;
(
    input  logic [6:0] code_i,
    output dec_t       dec_c_o
);

    always_comb begin
        dec_c_o = '{blank: 1'b0, invalid: 1'b0, nibble: 4'h0};
        case (code_i)
            SSEG_0:     dec_c_o.nibble = 4'h0;
            SSEG_1:     dec_c_o.nibble = 4'h1;
            SSEG_2:     dec_c_o.nibble = 4'h2;
            SSEG_3:     dec_c_o.nibble = 4'h3;
            SSEG_4:     dec_c_o.nibble = 4'h4;
            SSEG_5:     dec_c_o.nibble = 4'h5;
            SSEG_6:     dec_c_o.nibble = 4'h6;
            SSEG_7:     dec_c_o.nibble = 4'h7;
            SSEG_8:     dec_c_o.nibble = 4'h8;
            SSEG_9:     dec_c_o.nibble = 4'h9;
            SSEG_A:     dec_c_o.nibble = 4'hA;
            SSEG_B:     dec_c_o.nibble = 4'hB;
            SSEG_C:     dec_c_o.nibble = 4'hC;
            SSEG_D:     dec_c_o.nibble = 4'hD;
            SSEG_E:     dec_c_o.nibble = 4'hE;
            SSEG_F:     dec_c_o.nibble = 4'hF;
            SSEG_BLANK: dec_c_o.blank  = 1'b1;
            default:    dec_c_o.invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/sseg_scan_reader.sv
// Reader end of the multiplexed seven-segment bus: rebuilds an NDIG-digit word
// from the anode scan and pulses frame_valid once all digits have been seen.
module sseg_scan_reader
    import sseg_scan_reader_pkg::*;
#(
    parameter int unsigned NDIG    = 4,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input logic clk,
    input logic rst,
    sseg_scan_reader_if.slave bus
);

    localparam int unsigned DW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned SW = $clog2(SETTLE);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STAB_MAX = SW'(SETTLE - 1);
    localparam logic [TW-1:0] IDLE_MAX = TW'(TIMEOUT - 1);

    logic [NDIG-1:0]   an_q, an_p_q;
    logic [6:0]        sseg_q, sseg_p_q;
    logic              signo_q;
    logic [SW-1:0]     stab_q, stab_d;
    logic [TW-1:0]     idle_q;
    logic [NDIG-1:0]   mask_q;
    logic [4*NDIG-1:0] shadow_q;
    logic [NDIG-1:0]   blank_sh_q;
    logic              neg_acc_q, err_acc_q;
    state_e            state_q;
    logic [4*NDIG-1:0] value_q;
    logic [NDIG-1:0]   blank_q;
    logic              neg_q, err_q, fv_q, to_q;

    dec_t              dec_c;
    logic [DW-1:0]     dig_c;
    logic              steady_c, capture_c;
    logic [NDIG-1:0]   open_mask_c, mask_d;

    sseg_scan_reader_decode u_decode (
        .code_i  (sseg_q),
        .dec_c_o (dec_c)
    );

    always_comb begin
        dig_c = '0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (!an_q[i]) dig_c = DW'(i);
        end
    end

    // In DONE the mask is about to clear, so a capture there seeds the next frame.
    always_comb begin
        steady_c    = is_onehot_low({{(32 - NDIG){1'b1}}, an_q}) &&
                      (an_q == an_p_q) && (sseg_q == sseg_p_q);
        open_mask_c = (state_q == ST_DONE) ? '0 : mask_q;
        capture_c   = steady_c && (stab_q == STAB_MAX) && !open_mask_c[dig_c];
        mask_d      = open_mask_c | (capture_c ? (NDIG'(1) << dig_c) : '0);
        if (!steady_c)
            stab_d = '0;
        else if (stab_q != STAB_MAX)
            stab_d = stab_q + SW'(1);
        else
            stab_d = stab_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q       <= '1;
            an_p_q     <= '1;
            sseg_q     <= SSEG_BLANK;
            sseg_p_q   <= SSEG_BLANK;
            signo_q    <= 1'b0;
            stab_q     <= '0;
            idle_q     <= '0;
            mask_q     <= '0;
            shadow_q   <= '0;
            blank_sh_q <= '0;
            neg_acc_q  <= 1'b0;
            err_acc_q  <= 1'b0;
            state_q    <= ST_IDLE;
            value_q    <= '0;
            blank_q    <= '0;
            neg_q      <= 1'b0;
            err_q      <= 1'b0;
            fv_q       <= 1'b0;
            to_q       <= 1'b0;
        end else begin
            an_q     <= bus.an;
            an_p_q   <= an_q;
            sseg_q   <= bus.sseg;
            sseg_p_q <= sseg_q;
            signo_q  <= bus.signo;
            stab_q   <= stab_d;
            fv_q     <= 1'b0;
            to_q     <= 1'b0;

            if (capture_c) begin
                shadow_q[{dig_c, 2'b00} +: 4] <= dec_c.nibble;
                blank_sh_q[dig_c]             <= dec_c.blank;
            end
            mask_q    <= mask_d;
            neg_acc_q <= ((state_q == ST_DONE) ? 1'b0 : neg_acc_q) | (capture_c & signo_q);
            err_acc_q <= ((state_q == ST_DONE) ? 1'b0 : err_acc_q) | (capture_c & dec_c.invalid);

            case (state_q)
                ST_IDLE: begin
                    idle_q <= '0;
                    if (&mask_d)        state_q <= ST_DONE;
                    else if (capture_c) state_q <= ST_COLLECT;
                end
                ST_COLLECT: begin
                    if (&mask_d) begin
                        idle_q  <= '0;
                        state_q <= ST_DONE;
                    end else if (capture_c) begin
                        idle_q <= '0;
                    end else if (idle_q == IDLE_MAX) begin
                        // Abandon the partial frame; the last complete word stays visible.
                        to_q      <= 1'b1;
                        mask_q    <= '0;
                        neg_acc_q <= 1'b0;
                        err_acc_q <= 1'b0;
                        idle_q    <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        idle_q <= idle_q + TW'(1);
                    end
                end
                ST_DONE: begin
                    value_q <= shadow_q;
                    blank_q <= blank_sh_q;
                    neg_q   <= neg_acc_q;
                    err_q   <= err_acc_q;
                    fv_q    <= 1'b1;
                    idle_q  <= '0;
                    if (&mask_d)        state_q <= ST_DONE;
                    else if (capture_c) state_q <= ST_COLLECT;
                    else                state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.value       = value_q;
    assign bus.blank_mask  = blank_q;
    assign bus.neg         = neg_q;
    assign bus.frame_valid = fv_q;
    assign bus.err         = err_q;
    assign bus.timeout     = to_q;

endmodule

// File: tb/tb_sseg_scan_reader.sv
// Directed bench for sseg_scan_reader: drives anode scans and checks captured frames.
module tb_sseg_scan_reader;

    localparam int unsigned NDIG    = 4;
    localparam int unsigned TIMEOUT = 4096;

    localparam logic [6:0] CODE [16] = '{
        7'b0000001, 7'b1111001, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] BAD   = 7'b1010101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   fv_cnt = 0;
    int   to_cnt = 0;
    int   fv0, to0;

    sseg_scan_reader_if #(.NDIG(NDIG)) bus ();

    sseg_scan_reader #(
        .NDIG    (NDIG),
        .SETTLE  (4),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) fv_cnt++;
        if (bus.timeout === 1'b1)     to_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one digit pattern on the bus for a number of clock edges.
    task automatic show(input logic [3:0] an, input logic [6:0] code, input logic s, input int hold);
        bus.an    = an;
        bus.sseg  = code;
        bus.signo = s;
        cycles(hold);
    endtask

    task automatic idle_bus(input int n);
        show(4'b1111, BLANK, 1'b0, n);
    endtask

    // Last digit released right after its capture so nothing seeds a following frame.
    task automatic scan(input logic [6:0] c0, input logic [6:0] c1, input logic [6:0] c2,
                        input logic [6:0] c3, input logic s);
        show(4'b1110, c0, s, 8);
        show(4'b1101, c1, s, 8);
        show(4'b1011, c2, s, 8);
        show(4'b0111, c3, s, 5);
        idle_bus(6);
    endtask

    initial begin
        bus.an = 4'b1111; bus.sseg = BLANK; bus.signo = 1'b0;
        cycles(3);
        chk("rst_value", 32'(bus.value), 32'h0);
        chk("rst_blank", 32'(bus.blank_mask), 32'h0);
        chk("rst_neg", 32'(bus.neg), 32'h0);
        chk("rst_fv", 32'(bus.frame_valid), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        chk("rst_to", 32'(bus.timeout), 32'h0);
        rst = 1'b0;
        idle_bus(4);

        fv0 = fv_cnt;
        scan(CODE[4], CODE[3], CODE[2], CODE[1], 1'b0);
        chk("t1_fv", 32'(fv_cnt - fv0), 32'd1);
        chk("t1_value", 32'(bus.value), 32'h1234);
        chk("t1_blank", 32'(bus.blank_mask), 32'h0);
        chk("t1_neg", 32'(bus.neg), 32'h0);
        chk("t1_err", 32'(bus.err), 32'h0);

        fv0 = fv_cnt;
        scan(CODE[15], CODE[0], CODE[10], BLANK, 1'b1);
        chk("t2_fv", 32'(fv_cnt - fv0), 32'd1);
        chk("t2_value", 32'(bus.value), 32'h0A0F);
        chk("t2_blank", 32'(bus.blank_mask), 32'b1000);
        chk("t2_neg", 32'(bus.neg), 32'h1);
        chk("t2_err", 32'(bus.err), 32'h0);

        fv0 = fv_cnt;
        scan(CODE[1], CODE[2], BAD, CODE[3], 1'b0);
        chk("t3_fv", 32'(fv_cnt - fv0), 32'd1);
        chk("t3_err", 32'(bus.err), 32'h1);
        chk("t3_value", 32'(bus.value), 32'h3021);
        scan(CODE[5], CODE[6], CODE[7], CODE[8], 1'b0);
        chk("t3_clean_err", 32'(bus.err), 32'h0);
        chk("t3_clean_value", 32'(bus.value), 32'h8765);

        fv0 = fv_cnt;
        show(4'b1110, CODE[1], 1'b0, 2);
        show(4'b1101, CODE[2], 1'b0, 2);
        show(4'b1011, CODE[3], 1'b0, 2);
        show(4'b0111, CODE[4], 1'b0, 2);
        idle_bus(6);
        chk("t4_short_fv", 32'(fv_cnt - fv0), 32'd0);

        to0 = to_cnt;
        show(4'b1110, CODE[9], 1'b0, 8);
        show(4'b1101, CODE[9], 1'b0, 8);
        idle_bus(4000);
        chk("t4_to_early", 32'(to_cnt - to0), 32'd0);
        idle_bus(200);
        chk("t4_to_pulse", 32'(to_cnt - to0), 32'd1);
        chk("t4_to_fv", 32'(fv_cnt - fv0), 32'd0);
        chk("t4_to_value", 32'(bus.value), 32'h8765);

        fv0 = fv_cnt;
        show(4'b1100, CODE[7], 1'b0, 8);
        show(4'b1101, CODE[5], 1'b0, 3);
        show(4'b1101, CODE[8], 1'b0, 1);
        show(4'b1101, CODE[5], 1'b0, 3);
        scan(CODE[9], CODE[12], CODE[13], CODE[14], 1'b0);
        chk("t5_fv", 32'(fv_cnt - fv0), 32'd1);
        chk("t5_value", 32'(bus.value), 32'hEDC9);

        show(4'b1110, CODE[15], 1'b1, 8);
        show(4'b1101, CODE[15], 1'b1, 8);
        rst = 1'b1;
        cycles(2);
        chk("t6_rst_value", 32'(bus.value), 32'h0);
        chk("t6_rst_blank", 32'(bus.blank_mask), 32'h0);
        chk("t6_rst_neg", 32'(bus.neg), 32'h0);
        chk("t6_rst_err", 32'(bus.err), 32'h0);
        rst = 1'b0;
        idle_bus(4);
        fv0 = fv_cnt;
        scan(CODE[4], CODE[3], CODE[2], CODE[1], 1'b0);
        chk("t6_fv", 32'(fv_cnt - fv0), 32'd1);
        chk("t6_value", 32'(bus.value), 32'h1234);
        chk("t6_blank", 32'(bus.blank_mask), 32'h0);
        chk("t6_neg", 32'(bus.neg), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
